// File: rtl/linear_proj_bram_loader_if.sv
// Stream, dual-port BRAM write and matmul handshake bundle for the BRAM loader.
// The master modport is the loader side; slave is the feeder/BRAM/wrapper side.
interface linear_proj_bram_loader_if #(
  parameter int IN_WIDTH   = 64,
  parameter int ROW_WIDTH  = 256,
  parameter int ADDR_WIDTH = 4
);
  logic [IN_WIDTH-1:0]   s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_last;
  logic                  ena;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [ROW_WIDTH-1:0]  dina;
  logic                  enb;
  logic                  web;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [ROW_WIDTH-1:0]  dinb;
  logic                  mm_start;
  logic                  mm_done;

  modport master (
    input  s_data, s_valid, s_last, mm_done,
    output s_ready, ena, wea, addra, dina, enb, web, addrb, dinb, mm_start
  );

  modport slave (
    output s_data, s_valid, s_last, mm_done,
    input  s_ready, ena, wea, addra, dina, enb, web, addrb, dinb, mm_start
  );
endinterface

// File: rtl/linear_proj_bram_loader.sv
// Packs a narrow beat stream into BRAM rows, writes even/odd row pairs through
// both BRAM ports at once, then kicks the matmul wrapper and waits for done.
module linear_proj_bram_loader #(
  parameter int IN_WIDTH   = 64,
  parameter int ROW_WIDTH  = 256,
  parameter int NUM_ROWS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_start,
  linear_proj_bram_loader_if.master bus,
  output logic                      busy,
  output logic                      err
);
  localparam int BEATS = ROW_WIDTH / IN_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(NUM_ROWS - 1);
  localparam bit                    ROWS_ODD  = (NUM_ROWS % 2) == 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    FLUSH     = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [ADDR_WIDTH-1:0] r_row_cnt;
  logic [ROW_WIDTH-1:0]  r_buf_even;
  logic [ROW_WIDTH-1:0]  r_buf_odd;
  logic                  r_s_ready;
  logic                  r_ena;
  logic                  r_enb;
  logic [ADDR_WIDTH-1:0] r_addra;
  logic [ADDR_WIDTH-1:0] r_addrb;
  logic [ROW_WIDTH-1:0]  r_dina;
  logic [ROW_WIDTH-1:0]  r_dinb;
  logic                  r_mm_start;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_row_done;
  logic                  w_final_row;
  logic                  w_frame_err;
  logic                  w_wr_a;
  logic                  w_wr_b;
  logic [ADDR_WIDTH-1:0] w_addra;
  logic [ADDR_WIDTH-1:0] w_addrb;
  logic [ROW_WIDTH-1:0]  w_dina;
  logic [ROW_WIDTH-1:0]  w_dinb;
  logic [ROW_WIDTH-1:0]  w_merged;

  assign w_accept    = bus.s_valid && r_s_ready && (r_state == LOAD);
  assign w_row_done  = w_accept && (r_beat_cnt == LAST_BEAT);
  assign w_final_row = (r_row_cnt == LAST_ROW);
  // s_last is legal only on the very last beat of the last row
  assign w_frame_err = w_accept && bus.s_last && !(w_row_done && w_final_row);

  // Odd row as it will look once the beat being accepted is in place
  always_comb begin
    w_merged = r_buf_odd;
    w_merged[(BEATS-1)*IN_WIDTH +: IN_WIDTH] = bus.s_data;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and write-request decode
  always_comb begin
    w_next  = r_state;
    w_wr_a  = 1'b0;
    w_wr_b  = 1'b0;
    w_addra = r_addra;
    w_addrb = r_addrb;
    w_dina  = r_dina;
    w_dinb  = r_dinb;
    case (r_state)
      IDLE: begin
        if (load_start) w_next = LOAD;
        else            w_next = IDLE;
      end
      LOAD: begin
        if (w_frame_err) begin
          w_next = IDLE;
        end else if (w_row_done) begin
          if (r_row_cnt[0]) begin
            w_wr_a  = 1'b1;
            w_wr_b  = 1'b1;
            w_addra = r_row_cnt - ADDR_WIDTH'(1);
            w_addrb = r_row_cnt;
            w_dina  = r_buf_even;
            w_dinb  = w_merged;
          end else begin
            w_wr_a = 1'b0;
          end
          if (w_final_row) w_next = ROWS_ODD ? FLUSH : START;
          else             w_next = LOAD;
        end else begin
          w_next = LOAD;
        end
      end
      FLUSH: begin
        w_wr_a  = 1'b1;
        w_addra = LAST_ROW;
        w_dina  = r_buf_even;
        w_next  = START;
      end
      START: begin
        w_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.mm_done) w_next = IDLE;
        else             w_next = WAIT_DONE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ready  <= 1'b0;
      r_ena      <= 1'b0;
      r_enb      <= 1'b0;
      r_addra    <= '0;
      r_addrb    <= '0;
      r_dina     <= '0;
      r_dinb     <= '0;
      r_mm_start <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_s_ready  <= (w_next == LOAD);
      r_ena      <= w_wr_a;
      r_enb      <= w_wr_b;
      r_addra    <= w_addra;
      r_addrb    <= w_addrb;
      r_dina     <= w_dina;
      r_dinb     <= w_dinb;
      r_mm_start <= (r_state == START);
      r_busy     <= (w_next != IDLE);
      if (r_state == IDLE && load_start) r_err <= 1'b0;
      else if (w_frame_err)              r_err <= 1'b1;
      else                               r_err <= r_err;
    end
  end

  // Beat/row counters and row buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_row_cnt  <= '0;
      r_buf_even <= '0;
      r_buf_odd  <= '0;
    end else if (r_state == IDLE && load_start) begin
      r_beat_cnt <= '0;
      r_row_cnt  <= '0;
    end else if (w_accept && !w_frame_err) begin
      for (int k = 0; k < BEATS; k++) begin
        if (r_beat_cnt == CNT_W'(k)) begin
          if (r_row_cnt[0]) r_buf_odd[k*IN_WIDTH +: IN_WIDTH]  <= bus.s_data;
          else              r_buf_even[k*IN_WIDTH +: IN_WIDTH] <= bus.s_data;
        end
      end
      if (w_row_done) begin
        if (!w_final_row) begin
          r_beat_cnt <= '0;
          r_row_cnt  <= r_row_cnt + ADDR_WIDTH'(1);
        end
      end else begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.s_ready  = r_s_ready;
  assign bus.ena      = r_ena;
  assign bus.wea      = r_ena;
  assign bus.addra    = r_addra;
  assign bus.dina     = r_dina;
  assign bus.enb      = r_enb;
  assign bus.web      = r_enb;
  assign bus.addrb    = r_addrb;
  assign bus.dinb     = r_dinb;
  assign bus.mm_start = r_mm_start;
  assign busy         = r_busy;
  assign err          = r_err;
endmodule

// File: tb/tb_linear_proj_bram_loader.sv
// Directed bench: a 4-row loader (dut4) and a 3-row loader (dut3) share the stream;
// a negedge monitor logs every write strobe and mm_start with its cycle number.
module tb_linear_proj_bram_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ls4 = 1'b0;
  logic ls3 = 1'b0;
  logic [63:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic mm_done = 1'b0;
  logic busy4, err4, busy3, err3;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  typedef struct {
    int         cyc;
    logic       ena, wea, enb, web;
    logic [3:0] addra, addrb;
    logic [255:0] dina, dinb;
  } wr_t;

  wr_t wq4[$];
  wr_t wq3[$];
  int  st4[$];
  int  st3[$];
  wr_t m4, m3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  linear_proj_bram_loader_if #(.IN_WIDTH(64), .ROW_WIDTH(256), .ADDR_WIDTH(4)) if4 ();
  linear_proj_bram_loader_if #(.IN_WIDTH(64), .ROW_WIDTH(256), .ADDR_WIDTH(4)) if3 ();

  assign if4.s_data = s_data;  assign if3.s_data = s_data;
  assign if4.s_valid = s_valid; assign if3.s_valid = s_valid;
  assign if4.s_last = s_last;  assign if3.s_last = s_last;
  assign if4.mm_done = mm_done; assign if3.mm_done = mm_done;

  linear_proj_bram_loader #(.IN_WIDTH(64), .ROW_WIDTH(256), .NUM_ROWS(4), .ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_start(ls4), .bus(if4.master), .busy(busy4), .err(err4));
  linear_proj_bram_loader #(.IN_WIDTH(64), .ROW_WIDTH(256), .NUM_ROWS(3), .ADDR_WIDTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .load_start(ls3), .bus(if3.master), .busy(busy3), .err(err3));

  always @(negedge clk) begin
    if (if4.ena || if4.enb) begin
      m4.cyc = cyc; m4.ena = if4.ena; m4.wea = if4.wea; m4.enb = if4.enb; m4.web = if4.web;
      m4.addra = if4.addra; m4.addrb = if4.addrb; m4.dina = if4.dina; m4.dinb = if4.dinb;
      wq4.push_back(m4);
    end
    if (if3.ena || if3.enb) begin
      m3.cyc = cyc; m3.ena = if3.ena; m3.wea = if3.wea; m3.enb = if3.enb; m3.web = if3.web;
      m3.addra = if3.addra; m3.addrb = if3.addrb; m3.dina = if3.dina; m3.dinb = if3.dinb;
      wq3.push_back(m3);
    end
    if (if4.mm_start) st4.push_back(cyc);
    if (if3.mm_start) st3.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Row r holds beat values 4r..4r+3, first beat in the LSBs
  function automatic logic [255:0] row(input int r);
    return {64'(4*r+3), 64'(4*r+2), 64'(4*r+1), 64'(4*r)};
  endfunction

  task automatic start_load(input int sel);
    if (sel == 3) ls3 = 1'b1; else ls4 = 1'b1;
    tick();
    ls3 = 1'b0; ls4 = 1'b0;
  endtask

  task automatic push(input int sel, input int v, input bit last, input bit gap);
    logic rdy;
    s_data = 64'(v); s_valid = 1'b1; s_last = last;
    rdy = (sel == 3) ? if3.s_ready : if4.s_ready;
    chk("s_ready_in_load", 256'(rdy), 256'd1);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    if (gap) tick();
  endtask

  task automatic send(input int sel, input int first, input int cnt, input int last_at, input bit gap);
    for (int i = first; i < first + cnt; i++) push(sel, i, (i == last_at), gap);
  endtask

  task automatic wait_start(input int sel, input string tag);
    int n = 0;
    while (((sel == 3) ? st3.size() : st4.size()) == 0 && n < 20) begin tick(); n++; end
    chk(tag, 256'(((sel == 3) ? st3.size() : st4.size())), 256'd1);
  endtask

  task automatic chk_pair(input wr_t w, input int a, input string tag);
    chk({tag, "_strobes"}, 256'({w.ena, w.wea, w.enb, w.web}), 256'hF);
    chk({tag, "_addra"}, 256'(w.addra), 256'(a));
    chk({tag, "_addrb"}, 256'(w.addrb), 256'(a + 1));
    chk({tag, "_dina"}, w.dina, row(a));
    chk({tag, "_dinb"}, w.dinb, row(a + 1));
  endtask

  task automatic chk_full4(input string tag);
    chk({tag, "_nwrites"}, 256'(wq4.size()), 256'd2);
    if (wq4.size() >= 2) begin
      chk_pair(wq4[0], 0, {tag, "_w0"});
      chk_pair(wq4[1], 2, {tag, "_w1"});
      if (st4.size() >= 1) chk({tag, "_start_lat"}, 256'(st4[0]), 256'(wq4[1].cyc + 1));
    end
  endtask

  task automatic finish_done4(input string tag);
    repeat (3) tick();
    chk({tag, "_busy_wait"}, 256'(busy4), 256'd1);
    mm_done = 1'b1; tick(); mm_done = 1'b0;
    chk({tag, "_busy_idle"}, 256'(busy4), 256'd0);
    chk({tag, "_nstart"}, 256'(st4.size()), 256'd1);
  endtask

  task automatic clear_logs();
    wq4.delete(); wq3.delete(); st4.delete(); st3.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("reset_outs4", 256'({busy4, err4, if4.s_ready, if4.ena, if4.wea, if4.enb, if4.web,
                             if4.mm_start, |if4.addra, |if4.addrb, |if4.dina, |if4.dinb}), 256'd0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: back-to-back 16-beat load
    clear_logs();
    start_load(4);
    chk("s1_busy", 256'(busy4), 256'd1);
    chk("s1_row0_const", row(0),
        256'h0000000000000003_0000000000000002_0000000000000001_0000000000000000);
    send(4, 0, 16, 15, 1'b0);
    chk("s1_ready_drop", 256'(if4.s_ready), 256'd0);
    wait_start(4, "s1_start");
    chk_full4("s1");
    finish_done4("s1");

    // Scenario 2: odd row count, port-A-only flush
    clear_logs();
    start_load(3);
    send(3, 0, 12, 11, 1'b0);
    wait_start(3, "s2_start");
    chk("s2_nwrites", 256'(wq3.size()), 256'd2);
    if (wq3.size() >= 2) begin
      chk_pair(wq3[0], 0, "s2_w0");
      chk("s2_flush_a", 256'({wq3[1].ena, wq3[1].wea}), 256'h3);
      chk("s2_flush_b", 256'({wq3[1].enb, wq3[1].web}), 256'h0);
      chk("s2_flush_addr", 256'(wq3[1].addra), 256'd2);
      chk("s2_flush_data", wq3[1].dina, row(2));
      if (st3.size() >= 1) chk("s2_start_lat", 256'(st3[0]), 256'(wq3[1].cyc + 1));
    end
    chk("s2_dut4_quiet", 256'(wq4.size()), 256'd0);
    mm_done = 1'b1; tick(); mm_done = 1'b0;
    chk("s2_busy_idle", 256'(busy3), 256'd0);

    // Scenario 3: s_valid every other cycle
    clear_logs();
    start_load(4);
    send(4, 0, 16, 15, 1'b1);
    wait_start(4, "s3_start");
    chk_full4("s3");
    finish_done4("s3");

    // Scenario 4: premature s_last on beat 9, then a clean reload
    clear_logs();
    start_load(4);
    send(4, 0, 10, 9, 1'b0);
    tick();
    chk("s4_err", 256'(err4), 256'd1);
    chk("s4_busy", 256'(busy4), 256'd0);
    repeat (15) tick();
    chk("s4_nwrites", 256'(wq4.size()), 256'd1);
    chk("s4_nstart", 256'(st4.size()), 256'd0);
    clear_logs();
    start_load(4);
    chk("s4_err_clr", 256'(err4), 256'd0);
    send(4, 0, 16, 15, 1'b0);
    wait_start(4, "s4_start");
    chk_full4("s4");
    finish_done4("s4");

    // Scenario 5: load_start and mm_done during LOAD are ignored
    clear_logs();
    start_load(4);
    send(4, 0, 5, 99, 1'b0);
    ls4 = 1'b1; mm_done = 1'b1; tick(); ls4 = 1'b0; mm_done = 1'b0;
    chk("s5_busy", 256'(busy4), 256'd1);
    send(4, 5, 11, 15, 1'b0);
    wait_start(4, "s5_start");
    chk_full4("s5");
    finish_done4("s5");

    // Scenario 6: async reset mid-load, then a full load
    clear_logs();
    start_load(4);
    send(4, 0, 6, 99, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("s6_async_outs", 256'({busy4, err4, if4.s_ready, if4.ena, if4.enb, if4.mm_start}), 256'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    start_load(4);
    send(4, 0, 16, 15, 1'b0);
    wait_start(4, "s6_start");
    chk_full4("s6");
    finish_done4("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/linear_proj_bram_loader.md
Name: linear_proj_bram_loader

Overview:
- Upstream feeder for the linear-projection matmul wrapper.
- Accepts a narrow valid/ready stream of matrix data and packs consecutive beats into full BRAM rows.
- Writes row pairs through both BRAM ports in one cycle: even row on port A, odd row on port B.
- After the last row is written, pulses the wrapper's start and holds until the wrapper reports done.
- One instance is used per matrix (input or weight).

Parameters:
- IN_WIDTH, 64, stream beat width in bits.
- ROW_WIDTH, 256, BRAM row width in bits. Must be an integer multiple of IN_WIDTH. BEATS = ROW_WIDTH/IN_WIDTH, and BEATS ≥ 1.
- NUM_ROWS, 16, rows per load, ≥ 1. Odd values are allowed.
- ADDR_WIDTH, 4, BRAM address width, with 2^ADDR_WIDTH ≥ NUM_ROWS.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- s_data  in  IN_WIDTH  stream beat.
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- s_last  in  1  marks the final beat of the load.
- ena, wea  out  1, 1  port A enable and write strobe, asserted together.
- addra  out  ADDR_WIDTH  port A address (even row).
- dina  out  ROW_WIDTH  port A data.
- enb, web  out  1, 1  port B enable and write strobe.
- addrb  out  ADDR_WIDTH  port B address (odd row).
- dinb  out  ROW_WIDTH  port B data.
- mm_start  out  1  one-cycle start pulse to the matmul wrapper.
- mm_done  in  1  done from the matmul wrapper.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky framing error; cleared by load_start.

Behaviour:
- Reset: all outputs 0, every state register 0, FSM = IDLE.
- All outputs are registered.
- FSM states: IDLE, LOAD, FLUSH, START, WAIT_DONE.
  - IDLE: on load_start, clear err, beat_cnt, row_cnt → LOAD.
  - LOAD: s_ready = 1 (no bubbles).
  - FLUSH, START, WAIT_DONE: s_ready = 0.
- Packing order: the first beat of a row lands in bits [IN_WIDTH-1:0], beat k in bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
- Row buffers: even-row buffer and odd-row buffer. row_cnt[0] selects the buffer being filled.
- On accepting the final beat of an odd row r (row_cnt odd), the next edge registers:
  - ena = enb = wea = web = 1;
  - addra = r-1, dina = even buffer;
  - addrb = r, dinb = odd buffer with the incoming beat merged in.
  - Strobes last exactly one cycle. Buffers may be refilled on the following cycle. Write latency is 1 cycle after the accepting edge.
- Completing an even row does not write; it waits for its partner row.
- End of load is the acceptance of the final beat of row NUM_ROWS-1. The next state depends on the parity of NUM_ROWS:
  - NUM_ROWS even: the pair write occurs as above → START.
  - NUM_ROWS odd: → FLUSH. FLUSH issues a port-A-only write (ena = wea = 1, addra = NUM_ROWS-1, enb = web = 0) for one cycle → START.
- START: mm_start = 1 for exactly one cycle. It fires the cycle after the final write strobe → WAIT_DONE.
- WAIT_DONE: on mm_done = 1 → IDLE.
  - mm_done arriving in any other state is ignored.
  - load_start outside IDLE is ignored.
- Framing rules:
  - s_last with the final beat of the final row is correct.
  - s_last on any other accepted beat → err = 1, FSM → IDLE, no mm_start. Any pending pair is not written.
  - A missing s_last on the final beat is not an error; the load completes normally.
- s_valid low mid-row: counters hold and buffers hold, with no timeout.
- Asynchronous reset mid-load: all outputs drop to 0 immediately and the partial load is abandoned.
- Addresses never wrap, because row_cnt stops at NUM_ROWS-1.

Test Plan:
- Defaults IN_WIDTH=64, ROW_WIDTH=256, NUM_ROWS=4; load_start, then 16 beats of values 0..15 with s_valid held high and s_last on beat 15 → s_ready stays high throughout. Exactly two dual writes:
  - (addra 0, dina beats 3..0 with beat 0 in the LSBs; addrb 1, dinb beats 7..4);
  - (addra 2, addrb 3).
  - Then mm_start pulses 1 cycle after the second write. busy stays high until mm_done.
- NUM_ROWS=3, 12 beats → one dual write (addresses 0/1), then a port-A-only write at address 2 with enb = 0, then mm_start.
- Default config with s_valid toggled every other cycle → same addresses and data as scenario 1; write strobes are still exactly 1 cycle each.
- s_last asserted on beat 9 of 16 → err = 1; the write at addresses 2/3 never occurs; mm_start never pulses. The next load_start clears err and a clean load succeeds.
- load_start and mm_done pulsed during LOAD → both ignored. The load completes, WAIT_DONE is entered, and a later mm_done returns the FSM to IDLE with busy = 0.
- rst_n pulled low after 6 beats → all outputs 0 asynchronously. After release, a full load writes rows 0..3 correctly.
